// File: rtl/tl45_seq_divider.sv
// tl45_seq_divider
// Multi-cycle restoring divider, one quotient bit per clock, MSB first.
// Signed operands are divided as magnitudes and the signs restored in a
// final fix-up cycle, so results truncate toward zero and the remainder
// follows the dividend's sign.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      begin a division (ignored while busy or flushing)
//   i_signed     1 = two's-complement operands (sampled with i_start)
//   i_dividend   dividend (sampled with i_start)
//   i_divisor    divisor  (sampled with i_start)
//   i_flush      abort any operation in progress, results untouched
//   o_busy       high in CALC and FIXUP
//   o_valid      one-cycle pulse while the FSM sits in DONE
//   o_quotient   quotient, held until the next fix-up
//   o_remainder  remainder, held until the next fix-up
//   o_div_zero   divisor was zero (qualified by o_valid)
module tl45_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Two's-complement negate when n is set, pass-through otherwise.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                              input logic             n);
    logic [WIDTH-1:0] r;
    if (n) begin
      r = ~v + WIDTH'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] rem_r;        // partial remainder
  logic [WIDTH-1:0] quo_r;        // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dmag_r;       // divisor magnitude
  logic             qsign_r;
  logic             rsign_r;
  logic             dz_r;
  logic             busy_r;
  logic             valid_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             div_zero_r;

  logic             accept_s;
  logic             dvd_neg_s;
  logic             dvs_neg_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   trial_s;

  // Start acceptance, operand sign decode and the trial subtract.
  always_comb begin
    accept_s  = i_start & ~busy_r & ~i_flush;
    dvd_neg_s = i_signed & i_dividend[WIDTH-1];
    dvs_neg_s = i_signed & i_divisor[WIDTH-1];
    shifted_s = {rem_r, quo_r[WIDTH-1]};
    // shifted_s < 2*divisor, so the WIDTH+1-bit difference cannot wrap;
    // its top bit is the borrow.
    trial_s   = shifted_s - {1'b0, dmag_r};
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_s = state_r;
    if (i_flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_s = CALC;
          end else begin
            state_s = IDLE;
          end
        end
        CALC: begin
          if (cnt_r == LAST_ITER) begin
            state_s = FIXUP;
          end else begin
            state_s = CALC;
          end
        end
        FIXUP: state_s = DONE;
        DONE: begin
          if (accept_s) begin
            state_s = CALC;
          end else begin
            state_s = IDLE;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // State register plus status flags registered from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == CALC) || (state_s == FIXUP);
      valid_r <= (state_s == DONE);
    end
  end

  // Operand capture and one restoring iteration per CALC cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r   <= '0;
      rem_r   <= '0;
      quo_r   <= '0;
      dmag_r  <= '0;
      qsign_r <= 1'b0;
      rsign_r <= 1'b0;
      dz_r    <= 1'b0;
    end else if (accept_s) begin
      cnt_r   <= '0;
      rem_r   <= '0;
      quo_r   <= neg_if(i_dividend, dvd_neg_s);
      dmag_r  <= neg_if(i_divisor, dvs_neg_s);
      // A zero divisor must leave the all-ones quotient un-negated; the
      // remainder negation still restores the original dividend.
      qsign_r <= (dvd_neg_s ^ dvs_neg_s) & (i_divisor != '0);
      rsign_r <= dvd_neg_s;
      dz_r    <= (i_divisor == '0);
    end else if ((state_r == CALC) && !i_flush) begin
      cnt_r <= cnt_r + CW'(1);
      if (!trial_s[WIDTH]) begin
        rem_r <= trial_s[WIDTH-1:0];
        quo_r <= {quo_r[WIDTH-2:0], 1'b1};
      end else begin
        rem_r <= shifted_s[WIDTH-1:0];
        quo_r <= {quo_r[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Result registers: written only on a FIXUP cycle that is not flushed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      quotient_r  <= '0;
      remainder_r <= '0;
      div_zero_r  <= 1'b0;
    end else if ((state_r == FIXUP) && !i_flush) begin
      quotient_r  <= neg_if(quo_r, qsign_r);
      remainder_r <= neg_if(rem_r, rsign_r);
      div_zero_r  <= dz_r;
    end
  end

  assign o_busy      = busy_r;
  assign o_valid     = valid_r;
  assign o_quotient  = quotient_r;
  assign o_remainder = remainder_r;
  assign o_div_zero  = div_zero_r;

endmodule

// File: tb/tb_tl45_seq_divider.sv
// Self-checking bench for tl45_seq_divider (WIDTH = 32).
// A timing/arithmetic model predicts busy, valid and the held results on
// every cycle; directed vectors pin literal results and latencies.
module tb_tl45_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sgn = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] dvd = '0;
  logic [W-1:0] dvs = '0;
  logic         busy, valid, dz;
  logic [W-1:0] q, r;

  tl45_seq_divider #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_signed(sgn),
    .i_dividend(dvd), .i_divisor(dvs), .i_flush(flush),
    .o_busy(busy), .o_valid(valid), .o_quotient(q), .o_remainder(r),
    .o_div_zero(dz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Arithmetic reference: returns {quotient, remainder, div_zero}.
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
    longint sa, sb;
    logic [W-1:0] mq, mr;
    if (b == '0) begin
      mq = '1;
      mr = a;
      return {mq, mr, 1'b1};
    end
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      mq = W'(sa / sb);
      mr = W'(sa % sb);
    end else begin
      mq = a / b;
      mr = a % b;
    end
    return {mq, mr, 1'b0};
  endfunction

  // Model: an accepted start at edge n shows busy after edges n..n+32,
  // results change at edge n+33 and valid is high after edge n+33.
  logic         m_active = 1'b0;
  int           m_acc = 0;
  logic [2*W:0] pend = '0;
  logic [2*W:0] held = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      held     <= '0;
    end else if (flush) begin
      m_active <= 1'b0;
    end else begin
      if (m_active && (cyc - m_acc == 32)) held <= pend;
      if (start && !(m_active && (cyc - m_acc <= 32))) begin
        m_active <= 1'b1;
        m_acc    <= cyc + 1;
        pend     <= model(dvd, dvs, sgn);
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    check("busy",      W'(busy),  W'(m_active && (cyc - m_acc <= 32)));
    check("valid",     W'(valid), W'(m_active && (cyc - m_acc == 33)));
    check("quotient",  q,         held[2*W:W+1]);
    check("remainder", r,         held[W:1]);
    check("div_zero",  W'(dz),    W'(held[0]));
  end

  // Issue one division from idle and pin latency and literal results.
  task automatic run_div(input string nm, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eq,
                         input logic [W-1:0] er, input logic edz);
    int acc_e, k;
    logic [2*W:0] m;
    m = model(a, b, s);
    check({nm, " model q"}, m[2*W:W+1], eq);
    check({nm, " model r"}, m[W:1], er);
    @(posedge clk); #2;
    sgn = s; dvd = a; dvs = b; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    acc_e = cyc;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!valid && k < 60);
    if (!valid) begin
      check({nm, " timeout"}, W'(0), W'(1));
    end else begin
      check({nm, " latency"}, W'(cyc - acc_e), W'(33));
      check({nm, " q"}, q, eq);
      check({nm, " r"}, r, er);
      check({nm, " dz"}, W'(dz), W'(edz));
    end
  endtask

  task automatic wait_valid(input string nm, output int at);
    int k;
    k = 0;
    at = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!valid && k < 80);
    if (!valid) check({nm, " timeout"}, W'(0), W'(1));
    else at = cyc;
  endtask

  initial begin
    int v1, v2, nvalid;
    #12;
    check("reset q", q, 32'h0);
    check("reset busy", W'(busy), 32'h0);
    rst_n = 1'b1;

    run_div("udiv 100/7",  1'b0, 32'd100,       32'd7,          32'd14,        32'd2,        1'b0);
    run_div("sdiv -7/2",   1'b1, 32'hFFFFFFF9,  32'd2,          32'hFFFFFFFD,  32'hFFFFFFFF, 1'b0);
    run_div("sdiv 7/-2",   1'b1, 32'd7,         32'hFFFFFFFE,   32'hFFFFFFFD,  32'd1,        1'b0);
    run_div("div0",        1'b0, 32'h12345678,  32'h0,          32'hFFFFFFFF,  32'h12345678, 1'b1);
    run_div("sdiv0 -7/0",  1'b1, 32'hFFFFFFF9,  32'h0,          32'hFFFFFFFF,  32'hFFFFFFF9, 1'b1);
    run_div("ovf",         1'b1, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,  32'h0,        1'b0);
    run_div("udiv big",    1'b0, 32'hFFFFFFFF,  32'h10,         32'h0FFFFFFF,  32'hF,        1'b0);
    run_div("udiv x>y",    1'b0, 32'd5,         32'd9,          32'd0,         32'd5,        1'b0);

    // Back-to-back: start held through busy, re-accepted in DONE.
    @(posedge clk); #2;
    sgn = 1'b0; dvd = 32'd1000; dvs = 32'd10; start = 1'b1;
    wait_valid("b2b first", v1);
    check("b2b first q", q, 32'd100);
    check("b2b first r", r, 32'd0);
    dvd = 32'd1001;
    @(posedge clk); #2;
    start = 1'b0;
    wait_valid("b2b second", v2);
    check("b2b spacing", W'(v2 - v1), 32'd34);
    check("b2b second q", q, 32'd100);
    check("b2b second r", r, 32'd1);

    // Flush at CALC cycle 10: no valid, results retained.
    @(posedge clk); #2;
    dvd = 32'd50; dvs = 32'd3; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    nvalid = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid) nvalid++;
    end
    check("flush no valid", W'(nvalid), 32'd0);
    check("flush busy", W'(busy), 32'd0);
    check("flush keeps q", q, 32'd100);
    check("flush keeps r", r, 32'd1);

    // Flush wins over a simultaneous start.
    @(posedge clk); #2;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; flush = 1'b0;
    check("flush priority", W'(busy), 32'd0);

    // Asynchronous reset mid-CALC.
    @(posedge clk); #2;
    dvd = 32'd100; dvs = 32'd7; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst busy", W'(busy), 32'h0);
    check("arst valid", W'(valid), 32'h0);
    check("arst q", q, 32'h0);
    check("arst r", r, 32'h0);
    check("arst dz", W'(dz), 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    run_div("after reset", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
